hazard_fwd_unit: RTL

Pipeline hazard and forwarding controller for the 5-stage core. Tracks destination-register state of the instructions in E, M and W. Generates the select lines consumed by the datapath operand muxes: D-stage write-through, E-stage MEM/WB forwarding, load-use stall and branch flush. Sits beside the controller and drives the mux block's `D_rs*_data_sel` / `E_rs*_data_sel` inputs.

---
 rtl/hazard_pkg.sv | 42 ++++
 rtl/hazard_match.sv | 29 ++
 rtl/hazard_fwd_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
// Optional feature macro: HAZARD_FP_EN (adds FP register-file tagging to stage records).
package hazard_pkg;

    // Stage records store indices zero-extended to this width; REG_IDX_W must not exceed it.
    localparam int HZ_IDX_MAX_W = 8;

    // Operand select encoding consumed by the E-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_WB  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_RF  = 2'b10
    } fwd_sel_e;

    // Destination-register state of one in-flight instruction.
    typedef struct packed {
        logic                    valid;
        logic                    we;
        logic                    is_load;
`ifdef HAZARD_FP_EN
        logic                    rd_fp;
`endif
        logic [HZ_IDX_MAX_W-1:0] rd;
    } hz_stage_t;

    localparam hz_stage_t HZ_BUBBLE = '0;

    // Select for an operand entering E: the younger producer (now in E, next in M) wins.
    function automatic fwd_sel_e hz_pick_sel(input logic use_src,
                                             input logic e_match,
                                             input logic m_match);
        if (!use_src) begin
            return FWD_RF;
        end else if (e_match) begin
            return FWD_MEM;
        end else if (m_match) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one stage record against one source operand.
// Optional feature macro: HAZARD_FP_EN (match also requires equal register-file tag;
// the hard-wired-zero exclusion then applies only to the integer file).
module hazard_match
    import hazard_pkg::*;
(
    input  hz_stage_t                stage,
    input  logic [HZ_IDX_MAX_W-1:0]  src_idx,
`ifdef HAZARD_FP_EN
    input  logic                     src_fp,
`endif
    output logic                     match
);

    logic rd_live;
    logic same_file;

`ifdef HAZARD_FP_EN
    // f0 is an ordinary register; only integer x0 is hard-wired.
    assign rd_live   = stage.rd_fp || (stage.rd != '0);
    assign same_file = (stage.rd_fp == src_fp);
`else
    assign rd_live   = (stage.rd != '0);
    assign same_file = 1'b1;
`endif

    assign match = stage.valid && stage.we && rd_live && same_file && (stage.rd == src_idx);

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for the 5-stage core: tracks E/M/W destination
// state, precomputes registered E operand selects, and produces D write-through,
// load-use stall and branch flush controls.
// Optional feature macro: HAZARD_FP_EN (FP register-file flags on sources/destination).
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 D_valid,
    input  logic [REG_IDX_W-1:0] D_rs1_idx,
    input  logic [REG_IDX_W-1:0] D_rs2_idx,
    input  logic [REG_IDX_W-1:0] D_rd_idx,
    input  logic                 D_use_rs1,
    input  logic                 D_use_rs2,
    input  logic                 D_reg_we,
    input  logic                 D_is_load,
`ifdef HAZARD_FP_EN
    input  logic                 D_rs1_fp,
    input  logic                 D_rs2_fp,
    input  logic                 D_rd_fp,
`endif
    input  logic                 E_branch_taken,
    output logic                 stall,
    output logic                 D_flush,
    output logic                 E_flush,
    output logic                 D_rs1_data_sel,
    output logic                 D_rs2_data_sel,
    output logic [1:0]           E_rs1_data_sel,
    output logic [1:0]           E_rs2_data_sel
);

    hz_stage_t e_reg, m_reg, w_reg, e_next;
    fwd_sel_e  e_rs1_sel_reg, e_rs2_sel_reg;
    fwd_sel_e  e_rs1_sel_next, e_rs2_sel_next;

    // Match matrix, flattened as stage*2 + source: stage 0=E, 1=M, 2=W; source 0=rs1, 1=rs2.
    hz_stage_t                stage_arr   [3];
    logic [HZ_IDX_MAX_W-1:0]  src_idx_arr [2];
    logic [5:0]               match_flat;
    logic                     load_use;

    assign stage_arr[0]   = e_reg;
    assign stage_arr[1]   = m_reg;
    assign stage_arr[2]   = w_reg;
    assign src_idx_arr[0] = HZ_IDX_MAX_W'(D_rs1_idx);
    assign src_idx_arr[1] = HZ_IDX_MAX_W'(D_rs2_idx);

`ifdef HAZARD_FP_EN
    logic src_fp_arr [2];
    assign src_fp_arr[0] = D_rs1_fp;
    assign src_fp_arr[1] = D_rs2_fp;
`endif

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_match
            hazard_match u_match (
                .stage   (stage_arr[gi / 2]),
                .src_idx (src_idx_arr[gi % 2]),
`ifdef HAZARD_FP_EN
                .src_fp  (src_fp_arr[gi % 2]),
`endif
                .match   (match_flat[gi])
            );
        end
    endgenerate

    // A load in E cannot forward yet; hold D for one cycle unless a taken branch kills D anyway.
    assign load_use = D_valid && e_reg.is_load &&
                      ((match_flat[0] && D_use_rs1) || (match_flat[1] && D_use_rs2));
    assign stall    = load_use && !E_branch_taken;
    assign E_flush  = stall || E_branch_taken;
    assign D_flush  = E_branch_taken;

    // Register-file write-through: W writes this cycle, D reads the same register.
    assign D_rs1_data_sel = match_flat[4] && D_use_rs1;
    assign D_rs2_data_sel = match_flat[5] && D_use_rs2;

    assign E_rs1_data_sel = e_rs1_sel_reg;
    assign E_rs2_data_sel = e_rs2_sel_reg;

    // Build the record entering E; anything not transferring becomes a bubble.
    always_comb begin
        e_next         = HZ_BUBBLE;
        e_rs1_sel_next = FWD_RF;
        e_rs2_sel_next = FWD_RF;
        if (D_valid && !stall && !E_branch_taken) begin
            e_next.valid   = 1'b1;
            e_next.we      = D_reg_we;
            e_next.is_load = D_is_load;
            e_next.rd      = HZ_IDX_MAX_W'(D_rd_idx);
`ifdef HAZARD_FP_EN
            e_next.rd_fp   = D_rd_fp;
`endif
            e_rs1_sel_next = hz_pick_sel(D_use_rs1, match_flat[0], match_flat[2]);
            e_rs2_sel_next = hz_pick_sel(D_use_rs2, match_flat[1], match_flat[3]);
        end
    end

    // Advance stage records every cycle; reset empties the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_reg         <= HZ_BUBBLE;
            m_reg         <= HZ_BUBBLE;
            w_reg         <= HZ_BUBBLE;
            e_rs1_sel_reg <= FWD_RF;
            e_rs2_sel_reg <= FWD_RF;
        end else begin
            w_reg         <= m_reg;
            m_reg         <= e_reg;
            e_reg         <= e_next;
            e_rs1_sel_reg <= e_rs1_sel_next;
            e_rs2_sel_reg <= e_rs2_sel_next;
        end
    end

endmodule
